// File: rtl/ex_operand_forward.sv
// EX-stage operand forwarding unit with load-use interlock.
// Holds one issued instruction, resolves each source against EX/MEM and MEM/WB, and hands off through a registered slot.
module ex_operand_forward #(
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned ADDR_W  = 5,
    parameter int unsigned NUM_OPS = 2,
    parameter int unsigned CNT_W   = 16
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [NUM_OPS*ADDR_W-1:0]   in_src_addr,
    input  logic [NUM_OPS*DATA_W-1:0]   in_src_data,
    input  logic                        exm_wr_en,
    input  logic                        exm_is_load,
    input  logic [ADDR_W-1:0]           exm_dst,
    input  logic [DATA_W-1:0]           exm_data,
    input  logic                        wb_wr_en,
    input  logic [ADDR_W-1:0]           wb_dst,
    input  logic [DATA_W-1:0]           wb_data,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [NUM_OPS*DATA_W-1:0]   out_op_data,
    output logic [NUM_OPS*2-1:0]        out_fwd_sel,
    output logic                        stall,
    output logic [CNT_W-1:0]            stall_cnt
);

    typedef enum logic [1:0] {IDLE, RESOLVE, STALL} stateT;

    stateT                      state;
    stateT                      stateNext;
    logic [NUM_OPS*ADDR_W-1:0]  pendAddr;
    logic [NUM_OPS*DATA_W-1:0]  pendData;
    logic [NUM_OPS-1:0]         exmHit;
    logic [NUM_OPS-1:0]         wbHit;
    logic [NUM_OPS-1:0]         opHazard;
    logic [NUM_OPS*DATA_W-1:0]  resData;
    logic [NUM_OPS*2-1:0]       resSel;
    logic                       pending;
    logic                       accept;
    logic                       transfer;
    logic                       stallNow;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= stateNext;
        end
    end

    always_comb begin
        stateNext = state;
        case (state)
            IDLE: begin
                if (accept) begin
                    stateNext = RESOLVE;
                end
            end
            RESOLVE, STALL: begin
                if (transfer) begin
                    stateNext = IDLE;
                end else if (stallNow) begin
                    stateNext = STALL;
                end else begin
                    stateNext = RESOLVE;
                end
            end
            default: stateNext = IDLE;
        endcase
    end

    always_comb begin
        pending  = (state != IDLE);
        in_ready = (state == IDLE);
        accept   = in_valid && in_ready;
        stallNow = pending && (|opHazard);
        stall    = stallNow;
        transfer = pending && !stallNow && (!out_valid || out_ready);
    end

    // Register 0 never matches a bypass source, so its operand stays at the zero default.
    always_comb begin
        exmHit   = '0;
        wbHit    = '0;
        opHazard = '0;
        resData  = '0;
        resSel   = '0;
        for (int unsigned k = 0; k < NUM_OPS; k++) begin
            if (pendAddr[k*ADDR_W +: ADDR_W] != '0) begin
                exmHit[k] = exm_wr_en && (exm_dst == pendAddr[k*ADDR_W +: ADDR_W]);
                wbHit[k]  = wb_wr_en && (wb_dst == pendAddr[k*ADDR_W +: ADDR_W]);
                if (exmHit[k] && exm_is_load) begin
                    opHazard[k] = 1'b1;
                end else if (exmHit[k]) begin
                    resSel[k*2 +: 2]          = 2'b10;
                    resData[k*DATA_W +: DATA_W] = exm_data;
                end else if (wbHit[k]) begin
                    resSel[k*2 +: 2]          = 2'b01;
                    resData[k*DATA_W +: DATA_W] = wb_data;
                end else begin
                    resData[k*DATA_W +: DATA_W] = pendData[k*DATA_W +: DATA_W];
                end
            end
        end
    end

    // Retiring write-backs are folded into the stored operands so a value passing during a stall survives.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pendAddr <= '0;
            pendData <= '0;
        end else if (accept) begin
            pendAddr <= in_src_addr;
            pendData <= in_src_data;
        end else if (pending) begin
            for (int unsigned k = 0; k < NUM_OPS; k++) begin
                if (wbHit[k]) begin
                    pendData[k*DATA_W +: DATA_W] <= wb_data;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid   <= 1'b0;
            out_op_data <= '0;
            out_fwd_sel <= '0;
        end else if (transfer) begin
            out_valid   <= 1'b1;
            out_op_data <= resData;
            out_fwd_sel <= resSel;
        end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt <= '0;
        end else if (stallNow && (stall_cnt != '1)) begin
            stall_cnt <= stall_cnt + CNT_W'(1);
        end
    end

    holdUnderBackpressure: assert property (@(posedge clk) disable iff (!rst_n)
        (out_valid && !out_ready) |=> (out_valid && $stable(out_op_data) && $stable(out_fwd_sel)));

endmodule

// File: tb/tb_ex_operand_forward.sv
// Randomised and directed bench for ex_operand_forward with a scoreboard fed by a transaction-level model.
module tb_ex_operand_forward;

    localparam int unsigned DW      = 32;
    localparam int unsigned AW      = 5;
    localparam int unsigned NOPS    = 2;
    localparam int unsigned CW      = 4;
    localparam int unsigned CNT_MAX = (1 << CW) - 1;

    logic                 clk = 1'b0;
    logic                 rst_n;
    logic                 in_valid;
    logic                 in_ready;
    logic [NOPS*AW-1:0]   in_src_addr;
    logic [NOPS*DW-1:0]   in_src_data;
    logic                 exm_wr_en;
    logic                 exm_is_load;
    logic [AW-1:0]        exm_dst;
    logic [DW-1:0]        exm_data;
    logic                 wb_wr_en;
    logic [AW-1:0]        wb_dst;
    logic [DW-1:0]        wb_data;
    logic                 out_valid;
    logic                 out_ready;
    logic [NOPS*DW-1:0]   out_op_data;
    logic [NOPS*2-1:0]    out_fwd_sel;
    logic                 stall;
    logic [CW-1:0]        stall_cnt;

    ex_operand_forward #(.DATA_W(DW), .ADDR_W(AW), .NUM_OPS(NOPS), .CNT_W(CW)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_src_addr(in_src_addr), .in_src_data(in_src_data),
        .exm_wr_en(exm_wr_en), .exm_is_load(exm_is_load), .exm_dst(exm_dst), .exm_data(exm_data),
        .wb_wr_en(wb_wr_en), .wb_dst(wb_dst), .wb_data(wb_data),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_op_data(out_op_data), .out_fwd_sel(out_fwd_sel),
        .stall(stall), .stall_cnt(stall_cnt)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [NOPS*DW-1:0] data;
        logic [NOPS*2-1:0]  sel;
    } expT;

    expT          sbq[$];
    int           total = 0;
    int           bad   = 0;

    // Model: at most one instruction waiting, at most one result sitting at the output.
    bit           mHave;
    bit           mOutBusy;
    int unsigned  mStallCnt;
    logic [AW-1:0] mAddr [NOPS];
    logic [DW-1:0] mVal  [NOPS];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic modelReset();
        mHave     = 1'b0;
        mOutBusy  = 1'b0;
        mStallCnt = 0;
        sbq.delete();
    endtask

    // Value an operand takes this cycle: youngest producer wins, register 0 reads as zero.
    function automatic void resolveOp(input logic [AW-1:0] a, input logic [DW-1:0] stored,
                                      output logic [DW-1:0] d, output logic [1:0] s);
        if (a == 0) begin
            d = '0; s = 2'b00;
        end else if (exm_wr_en && exm_dst == a) begin
            d = exm_data; s = 2'b10;
        end else if (wb_wr_en && wb_dst == a) begin
            d = wb_data; s = 2'b01;
        end else begin
            d = stored; s = 2'b00;
        end
    endfunction

    task automatic modelStep();
        bit hz, xfer, cons, rdy;
        expT e;
        logic [DW-1:0] d;
        logic [1:0] s;
        rdy = !mHave;
        hz  = 1'b0;
        if (mHave)
            for (int unsigned k = 0; k < NOPS; k++)
                if (mAddr[k] != 0 && exm_wr_en && exm_is_load && exm_dst == mAddr[k]) hz = 1'b1;
        chk("in_ready",  64'(in_ready),  64'(rdy));
        chk("stall",     64'(stall),     64'(hz));
        chk("stall_cnt", 64'(stall_cnt), 64'(mStallCnt));
        chk("out_valid", 64'(out_valid), 64'(mOutBusy));
        xfer = mHave && !hz && (!mOutBusy || out_ready);
        cons = mOutBusy && out_ready;
        if (xfer) begin
            e = '0;
            for (int unsigned k = 0; k < NOPS; k++) begin
                resolveOp(mAddr[k], mVal[k], d, s);
                e.data[k*DW +: DW] = d;
                e.sel[k*2 +: 2]    = s;
            end
            sbq.push_back(e);
        end
        if (mHave)
            for (int unsigned k = 0; k < NOPS; k++)
                if (mAddr[k] != 0 && wb_wr_en && wb_dst == mAddr[k]) mVal[k] = wb_data;
        if (hz && mStallCnt < CNT_MAX) mStallCnt++;
        if (xfer) begin
            mHave = 1'b0; mOutBusy = 1'b1;
        end else if (cons) begin
            mOutBusy = 1'b0;
        end
        if (rdy && in_valid) begin
            mHave = 1'b1;
            for (int unsigned k = 0; k < NOPS; k++) begin
                mAddr[k] = in_src_addr[k*AW +: AW];
                mVal[k]  = in_src_data[k*DW +: DW];
            end
        end
    endtask

    task automatic setInputs(input int iv, input int a0, input int a1, input int d0, input int d1,
                             input int xe, input int xl, input int xd, input int xdat,
                             input int we, input int wd, input int wdat, input int ordy);
        in_valid    = (iv != 0);
        in_src_addr = {AW'(a1), AW'(a0)};
        in_src_data = {DW'(d1), DW'(d0)};
        exm_wr_en   = (xe != 0);
        exm_is_load = (xl != 0);
        exm_dst     = AW'(xd);
        exm_data    = DW'(xdat);
        wb_wr_en    = (we != 0);
        wb_dst      = AW'(wd);
        wb_data     = DW'(wdat);
        out_ready   = (ordy != 0);
    endtask

    task automatic drive(input int iv, input int a0, input int a1, input int d0, input int d1,
                         input int xe, input int xl, input int xd, input int xdat,
                         input int we, input int wd, input int wdat, input int ordy);
        @(negedge clk);
        setInputs(iv, a0, a1, d0, d1, xe, xl, xd, xdat, we, wd, wdat, ordy);
        #1 modelStep();
    endtask

    task automatic idle(input int ordy);
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, ordy);
    endtask

    // Output monitor: the presented result is always the oldest expected entry.
    initial begin
        forever begin
            @(negedge clk);
            #2;
            if (rst_n && out_valid) begin
                if (sbq.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_output: got data %0h with no expected entry at %0t", out_op_data, $time);
                end else begin
                    chk("op_data", 64'(out_op_data), 64'(sbq[0].data));
                    chk("fwd_sel", 64'(out_fwd_sel), 64'(sbq[0].sel));
                    if (out_ready) void'(sbq.pop_front());
                end
            end
        end
    end

    initial begin
        logic [NOPS*AW-1:0] ra;
        logic [NOPS*DW-1:0] rd;
        rst_n = 1'b0;
        setInputs(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        modelReset();
        repeat (2) @(negedge clk);
        #1;
        chk("rst_out_valid", 64'(out_valid),   64'(0));
        chk("rst_op_data",   64'(out_op_data), 64'(0));
        chk("rst_fwd_sel",   64'(out_fwd_sel), 64'(0));
        chk("rst_stall",     64'(stall),       64'(0));
        chk("rst_stall_cnt", 64'(stall_cnt),   64'(0));
        chk("rst_in_ready",  64'(in_ready),    64'(1));
        @(negedge clk);
        rst_n = 1'b1;

        // No hits
        drive(1, 3, 4, 'h11, 'h22, 0, 0, 0, 0, 0, 0, 0, 1);
        idle(1); idle(1); idle(1);
        // EX/MEM beats MEM/WB, then MEM/WB alone
        drive(1, 5, 6, 1, 2, 0, 0, 0, 0, 0, 0, 0, 1);
        drive(0, 0, 0, 0, 0, 1, 0, 5, 'hAA, 1, 5, 'hBB, 1);
        idle(1);
        drive(1, 5, 6, 1, 2, 0, 0, 0, 0, 0, 0, 0, 1);
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 5, 'hBB, 1);
        idle(1); idle(1);
        // Load-use: one stall cycle, then the value retires through MEM/WB
        drive(1, 2, 7, 3, 4, 0, 0, 0, 0, 0, 0, 0, 1);
        drive(0, 0, 0, 0, 0, 1, 1, 7, 'hDEAD, 0, 0, 0, 1);
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 7, 'h55, 1);
        idle(1);
        chk("t3_stall_cnt", 64'(stall_cnt), 64'(1));
        idle(1);
        // Zero register ignores data and bypass hits, even a load
        drive(1, 0, 9, 'h99, 'h12, 0, 0, 0, 0, 0, 0, 0, 1);
        drive(0, 0, 0, 0, 0, 1, 1, 0, 'hFF, 1, 0, 'hEE, 1);
        idle(1); idle(1);
        // Backpressure with a second instruction waiting
        drive(1, 8, 9, 'hA1, 'hA2, 0, 0, 0, 0, 0, 0, 0, 0);
        idle(0);
        drive(1, 10, 11, 'hB1, 'hB2, 0, 0, 0, 0, 0, 0, 0, 0);
        idle(0); idle(0); idle(0);
        idle(1); idle(1); idle(1);
        // Counter saturation
        drive(1, 0, 7, 1, 2, 0, 0, 0, 0, 0, 0, 0, 1);
        repeat (20) drive(0, 0, 0, 0, 0, 1, 1, 7, 0, 0, 0, 0, 1);
        idle(1);
        chk("sat_stall_cnt", 64'(stall_cnt), 64'(CNT_MAX));
        idle(1); idle(1);
        // Reset in the middle of a stall
        drive(1, 7, 3, 5, 6, 0, 0, 0, 0, 0, 0, 0, 1);
        drive(0, 0, 0, 0, 0, 1, 1, 7, 0, 0, 0, 0, 1);
        drive(0, 0, 0, 0, 0, 1, 1, 7, 0, 0, 0, 0, 1);
        @(negedge clk);
        rst_n = 1'b0;
        setInputs(0, 0, 0, 0, 0, 1, 1, 7, 0, 0, 0, 0, 1);
        modelReset();
        #1;
        chk("mid_rst_out_valid", 64'(out_valid), 64'(0));
        chk("mid_rst_stall",     64'(stall),     64'(0));
        chk("mid_rst_stall_cnt", 64'(stall_cnt), 64'(0));
        @(negedge clk);
        rst_n = 1'b1;
        setInputs(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        #1;
        chk("post_rst_in_ready", 64'(in_ready), 64'(1));
        modelStep();

        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            for (int unsigned k = 0; k < NOPS; k++) begin
                ra[k*AW +: AW] = AW'($urandom_range(0, 7));
                rd[k*DW +: DW] = $urandom;
            end
            in_valid    = ($urandom_range(0, 9) < 7);
            in_src_addr = ra;
            in_src_data = rd;
            exm_wr_en   = ($urandom_range(0, 1) == 1);
            exm_is_load = ($urandom_range(0, 9) < 3);
            exm_dst     = AW'($urandom_range(0, 7));
            exm_data    = $urandom;
            wb_wr_en    = ($urandom_range(0, 1) == 1);
            wb_dst      = AW'($urandom_range(0, 7));
            wb_data     = $urandom;
            out_ready   = ($urandom_range(0, 9) < 7);
            #1 modelStep();
        end

        repeat (6) idle(1);
        chk("sb_drain",        64'(sbq.size()), 64'(0));
        chk("final_out_valid", 64'(out_valid),  64'(0));
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
